// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive path: FSM state encoding and scancode prefixes.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

endpackage

// File: rtl/ps2_filter.sv
// Input conditioning for PS/2: 2-FF synchronisers on clock and data, a
// FILTER_LEN-sample glitch filter on the clock, and a falling-edge strobe.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic data_sync,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic [CW-1:0] cnt_q;
  logic          filt_q;
  logic          filt_prev_q;

  // cnt_q counts consecutive samples disagreeing with the filtered level;
  // the level flips on the FILTER_LEN-th such sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      cnt_q       <= '0;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
      filt_prev_q <= filt_q;
      if (clk_sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= ~filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign data_sync = data_sync_q[1];
  assign fall      = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver; folds E0/F0 prefixes into flags on the next byte.
// Define PS2_TIMEOUT_EN to abort frames whose clock stalls for TIMEOUT_CYCLES.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_brk,
  output logic       code_valid,
  output logic       frame_err,
  output logic       busy,
  output ps2_state_e dbg_state
);

  logic data, fall;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .data_sync (data),
    .fall      (fall)
  );

  ps2_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;
  logic [7:0] code_q, code_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic       valid_q, valid_d, err_q, err_d;

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      code_q     <= '0;
      ext_q      <= 1'b0;
      brk_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
      code_q     <= code_d;
      ext_q      <= ext_d;
      brk_q      <= brk_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
`ifdef PS2_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    code_d     = code_q;
    ext_d      = ext_q;
    brk_d      = brk_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: if (fall) begin
        if (!data) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end
      DATA: if (fall) begin
        shreg_d   = {data, shreg_q[7:1]};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = data;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        // Odd parity: the eight data bits plus parity carry an odd number of ones.
        if (data && (^{shreg_q, par_q})) begin
          if (shreg_q == PS2_EXT) begin
            ext_pend_d = 1'b1;
          end else if (shreg_q == PS2_BRK) begin
            brk_pend_d = 1'b1;
          end else begin
            code_d     = shreg_q;
            ext_d      = ext_pend_q;
            brk_d      = brk_pend_q;
            valid_d    = 1'b1;
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
          end
        end else begin
          err_d      = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TIMEOUT_EN
    if (state_q != IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d    = IDLE;
      err_d      = 1'b1;
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
    to_cnt_d = (fall || state_d == IDLE) ? '0 : to_cnt_q + 1'b1;
`endif
  end

  assign code       = code_q;
  assign code_ext   = ext_q;
  assign code_brk   = brk_q;
  assign code_valid = valid_q;
  assign frame_err  = err_q;
  assign busy       = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of frames with expected events, plus start-error,
// mid-frame reset and (with PS2_TIMEOUT_EN) clock-stall sequences.
module tb_ps2_rx;
  import ps2_pkg::*;

  localparam int TO   = 1000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_ext, code_brk, code_valid, frame_err, busy;
  ps2_state_e dbg_state;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_ext   (code_ext),
    .code_brk   (code_brk),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;
  int n_both = 0;

  always @(negedge clk) begin
    if (code_valid) n_valid++;
    if (frame_err) n_err++;
    if (code_valid && frame_err) n_both++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // bits[0] goes on the wire first; glitches hit data-bit high phases only.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(10);
      if (glitch && i >= 1 && i <= 8) begin
        ps2_clk = 1'b0;
        #50;
        ps2_clk = 1'b1;
        wait_cyc(HALF - 15);
      end else begin
        wait_cyc(HALF - 10);
      end
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    bit         glitch;
    int         exp_valid;
    int         exp_err;
    logic [7:0] exp_code;
    bit         exp_ext;
    bit         exp_brk;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0, 0};
    vecs[1]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[2]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0, 1};
    vecs[3]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h1C, 0, 0};
    vecs[4]  = '{8'hE0, 0, 0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[5]  = '{8'hF0, 0, 0, 0, 0, 0, 8'h1C, 0, 0};
    vecs[6]  = '{8'h75, 0, 0, 0, 1, 0, 8'h75, 1, 1};
    vecs[7]  = '{8'h1C, 1, 0, 0, 0, 1, 8'h75, 1, 1};
    vecs[8]  = '{8'h32, 0, 0, 0, 1, 0, 8'h32, 0, 0};
    vecs[9]  = '{8'h44, 0, 1, 0, 0, 1, 8'h32, 0, 0};
    vecs[10] = '{8'h29, 0, 0, 1, 1, 0, 8'h29, 0, 0};
    vecs[11] = '{8'hE0, 0, 0, 0, 0, 0, 8'h29, 0, 0};
    vecs[12] = '{8'hE0, 0, 0, 0, 0, 0, 8'h29, 0, 0};
    vecs[13] = '{8'h6B, 0, 0, 0, 1, 0, 8'h6B, 1, 0};
    vecs[14] = '{8'hF0, 0, 0, 0, 0, 0, 8'h6B, 1, 0};
    vecs[15] = '{8'h1C, 1, 0, 0, 0, 1, 8'h6B, 1, 0};
    vecs[16] = '{8'h5A, 0, 0, 0, 1, 0, 8'h5A, 0, 0};
    vecs[17] = '{8'hF0, 0, 0, 1, 0, 0, 8'h5A, 0, 0};
    vecs[18] = '{8'hF0, 0, 0, 0, 0, 0, 8'h5A, 0, 0};
    vecs[19] = '{8'h12, 0, 0, 0, 1, 0, 8'h12, 0, 1};

    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(5);
    check("reset_code", code, 8'h00);
    check("reset_ext", code_ext, 0);
    check("reset_brk", code_brk, 0);
    check("reset_valid", code_valid, 0);
    check("reset_err", frame_err, 0);
    check("reset_busy", busy, 0);
    check("reset_state", dbg_state, IDLE);

    for (int i = 0; i < 20; i++) begin
      n_valid = 0;
      n_err = 0;
      send_bits(frame_bits(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop), 11, vecs[i].glitch);
      wait_cyc(20);
      check($sformatf("v%0d_valid_cnt", i), n_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_err_cnt", i), n_err, vecs[i].exp_err);
      check($sformatf("v%0d_code", i), code, vecs[i].exp_code);
      check($sformatf("v%0d_ext", i), code_ext, vecs[i].exp_ext);
      check($sformatf("v%0d_brk", i), code_brk, vecs[i].exp_brk);
      check($sformatf("v%0d_busy", i), busy, 0);
    end

    // A fall with data high while idle is a start-bit error.
    n_valid = 0;
    n_err = 0;
    send_bits(11'h7FF, 1, 0);
    wait_cyc(20);
    check("start_err_cnt", n_err, 1);
    check("start_valid_cnt", n_valid, 0);
    check("start_busy", busy, 0);

    // Reset mid-frame discards the partial frame and clears every output.
    send_bits(frame_bits(8'h5A, 0, 0), 5, 0);
    check("mid_busy", busy, 1);
    rst = 1'b1;
    wait_cyc(3);
    check("rst_code", code, 8'h00);
    check("rst_ext", code_ext, 0);
    check("rst_brk", code_brk, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    wait_cyc(5);
    n_valid = 0;
    n_err = 0;
    send_bits(frame_bits(8'h3B, 0, 0), 11, 0);
    wait_cyc(20);
    check("post_rst_valid_cnt", n_valid, 1);
    check("post_rst_err_cnt", n_err, 0);
    check("post_rst_code", code, 8'h3B);

`ifdef PS2_TIMEOUT_EN
    begin
      int t;
      n_valid = 0;
      n_err = 0;
      send_bits(frame_bits(8'h5A, 0, 0), 5, 0);
      check("to_busy_before", busy, 1);
      // Last fall was detected roughly 30 cycles before send_bits returned.
      t = 0;
      while (!frame_err && t < TO + 200) begin
        @(negedge clk);
        t++;
      end
      check("to_err_seen", frame_err, 1);
      check("to_latency_ok", (t >= TO - 60 && t <= TO) ? 1 : 0, 1);
      wait_cyc(2);
      check("to_busy_after", busy, 0);
      check("to_err_cnt", n_err, 1);
      n_valid = 0;
      n_err = 0;
      send_bits(frame_bits(8'h5A, 0, 0), 11, 0);
      wait_cyc(20);
      check("to_next_valid_cnt", n_valid, 1);
      check("to_next_code", code, 8'h5A);
    end
`endif

    check("no_valid_err_overlap", n_both, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
- PS/2 receive front end for the keyboard path. Samples raw ps2_clk/ps2_data and deserialises 11-bit device-to-host frames.
- Folds E0 (extended) and F0 (break) prefixes into flags on the following byte.
- Presents one make/break event per key as a single-cycle valid pulse.
- Sits directly upstream of the key-to-sel/data decoder that drives the character display's selection input.

Parameters:
- FILTER_LEN, 8, number of consecutive identical synchronised samples needed before ps2_clk is accepted as a new level (glitch filter).
- TIMEOUT_CYCLES, 200000, clk cycles allowed between ps2_clk falling edges inside a frame (2 ms at 100 MHz).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous active-high reset.
- ps2_clk  in  1  raw PS/2 clock from the pin; asynchronous.
- ps2_data  in  1  raw PS/2 data from the pin; asynchronous.
- code  out  8  scancode of the last completed event; holds until the next event.
- code_ext  out  1  event was preceded by E0.
- code_brk  out  1  event was preceded by F0 (key release).
- code_valid  out  1  one-cycle pulse; code/code_ext/code_brk are valid in this cycle.
- frame_err  out  1  one-cycle pulse on a start, parity, stop or timeout error.
- busy  out  1  high while a frame is being received (state != IDLE).

Behaviour:
- Reset: all outputs 0. Synchroniser and filter registers are set to 1 (idle bus level). State is IDLE; ext/brk pending flags and bit counter are 0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
  - Filtered clock changes level only after FILTER_LEN equal consecutive samples.
  - fall = filtered clock was 1 last cycle and is 0 this cycle. Data is sampled from the synchronised ps2_data on fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall, if data=0 go to DATA with bit_cnt=0. If data=1, assert frame_err and stay in IDLE.
  - DATA: on each fall, shift the data bit into shreg LSB-first (new bit enters bit 7, shifts right). After the 8th bit (bit_cnt==7) go to PARITY.
  - PARITY: on fall, store the bit and go to STOP.
  - STOP: on fall, the frame is good if stop=1 and ^{shreg,parity}==1 (odd parity); go to IDLE either way.
- Good frame, byte handling (outputs appear the cycle after the stop-bit fall; latency 1 cycle):
  - 8'hE0: set ext_pend; no pulse.
  - 8'hF0: set brk_pend; no pulse.
  - Any other byte: code<=byte, code_ext<=ext_pend, code_brk<=brk_pend, code_valid=1, then clear both pending flags.
- Bad frame (parity or stop wrong): frame_err=1 for one cycle, clear ext_pend/brk_pend, no code_valid. code holds its old value.
- Sequence E0 F0 xx yields exactly one pulse, with ext=1 and brk=1. A repeated E0 or F0 before the final byte keeps its flag set.
- code_valid and frame_err are never high in the same cycle.
- Asynchronous reset mid-frame discards the partial frame. The first fall after release is treated as a start bit.

Optional Feature:
- PS2_TIMEOUT_EN.
- Defined:
  - A counter clears on every fall and increments in DATA/PARITY/STOP.
  - When it reaches TIMEOUT_CYCLES-1: frame_err pulses, state goes to IDLE, pending flags clear.
  - The counter is held at 0 in IDLE.
- Undefined: no counter is built, and the FSM waits indefinitely for the next edge.

Decomposition:
- Shared package ps2_pkg: state encoding constants (IDLE=2'd0, DATA=2'd1, PARITY=2'd2, STOP=2'd3) and the prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
- One sub-module, ps2_filter: 2-FF synchroniser plus FILTER_LEN debounce plus falling-edge detect. It is instantiated once for ps2_clk; ps2_data uses only the synchroniser part.

Test Plan:
- Send frame 0x1C (start 0, bits 0011_1000 LSB-first, parity 0, stop 1) at 12.5 kHz -> one code_valid with code=8'h1C, code_ext=0, code_brk=0, frame_err never high.
- Send F0 then 1C -> no pulse after F0; after 1C one pulse with code=8'h1C, code_brk=1, code_ext=0. A following 1C gives code_brk=0.
- Send E0, F0, 75 -> exactly one pulse, code=8'h75, code_ext=1, code_brk=1.
- Send 0x1C with parity bit flipped -> frame_err one cycle, no code_valid, code keeps its previous value; the next clean 0x32 is received correctly.
- Inject 50 ns ps2_clk glitches (shorter than FILTER_LEN cycles) during the data bits of 0x29 -> code=8'h29 received, no frame_err.
- With PS2_TIMEOUT_EN: stop ps2_clk after 4 data bits for 3 ms -> frame_err at TIMEOUT_CYCLES after the last fall, busy drops, the next full 0x5A frame is received. Also assert rst mid-frame -> all outputs 0, next frame received cleanly.
